// File: rtl/riscv_multi_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and the datapath mux/ALU select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BEQ,
        S_JAL,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_multi_ctrl_if.sv
// Control/status bundle between the multicycle datapath (master) and its
// control FSM (slave).
interface riscv_multi_ctrl_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_we;
    logic       adr_src;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       err;

    modport master (
        output op, funct3, funct7b5, zero,
        input  pc_we, adr_src, mem_we, ir_we, reg_we, result_src,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done, err
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output pc_we, adr_src, mem_we, ir_we, reg_we, result_src,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, instr_done, err
    );

endinterface

// File: rtl/riscv_multi_ctrl_alu_dec.sv
// ALU operation decode from funct3/funct7b5; also reports whether funct3 names
// a supported operation. Shared with the single-cycle control path.
module riscv_alu_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_r,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            3'b000:  alu_ctrl = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multi_ctrl.sv
// Multicycle RV32I control FSM: sequences one instruction at a time through the
// shared-memory datapath, driving every mux select and write enable.
module riscv_multi_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic                clk,
    input  logic                rst,
    riscv_multi_ctrl_if.slave   bus
);

    localparam int unsigned HOLD_W = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                hold_active;
    logic [2:0]          dec_alu_ctrl;
    logic                dec_legal;

    logic       pc_we, adr_src, mem_we, ir_we, reg_we, instr_done, err;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;

    riscv_alu_dec u_alu_dec (
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .is_r     (bus.op == OP_R),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    assign hold_active = (hold_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            hold_q  <= HOLD_W'(RESET_PC_HOLD);
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // The hold counter only ever runs in FETCH, which idles until it drains.
    always_comb begin
        hold_d  = hold_active ? hold_q - 1'b1 : hold_q;
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = hold_active ? S_FETCH : S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = dec_legal ? S_EXEC_R : S_ERROR;
                    OP_I:         state_d = dec_legal ? S_EXEC_I : S_ERROR;
                    OP_B:         state_d = (bus.funct3 == 3'b000) ? S_BEQ : S_ERROR;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEM_ADR: state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = S_MEM_WB;
            S_MEM_WB:  state_d = S_FETCH;
            S_MEM_WR:  state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALU_WB;
            S_EXEC_I:  state_d = S_ALU_WB;
            S_ALU_WB:  state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            S_JAL:     state_d = S_ALU_WB;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        adr_src    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        err        = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_ctrl   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (bus.op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEM_RD:  adr_src = 1'b1;
            S_MEM_WB: begin
                result_src = RES_MEMDATA;
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                adr_src    = 1'b1;
                mem_we     = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_ctrl  = dec_alu_ctrl;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dec_alu_ctrl;
            end
            S_ALU_WB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_ctrl   = ALU_SUB;
                pc_we      = bus.zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_we     = 1'b1;
            end
            S_ERROR:   err = 1'b1;
            default: ;
        endcase
        // rst is gated in directly so writes drop in the same cycle it rises.
        if (rst || hold_active) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            mem_we = 1'b0;
            reg_we = 1'b0;
        end
    end

    assign bus.pc_we      = pc_we;
    assign bus.adr_src    = adr_src;
    assign bus.mem_we     = mem_we;
    assign bus.ir_we      = ir_we;
    assign bus.reg_we     = reg_we;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.imm_src    = imm_src;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.instr_done = instr_done;
    assign bus.err        = err;

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Bench for riscv_multi_ctrl: directed and random instruction streams compared
// cycle by cycle against a per-instruction control-word model.
module tb_riscv_multi_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       adr_src;
        logic       mem_we;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       err;
    } cw_t;

    // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal opcode
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [2:0]  legal_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};

    riscv_multi_ctrl_if bus ();
    riscv_multi_ctrl_if bus0 ();

    riscv_multi_ctrl #(.RESET_PC_HOLD(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    riscv_multi_ctrl #(.RESET_PC_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    assign bus0.op       = bus.op;
    assign bus0.funct3   = bus.funct3;
    assign bus0.funct7b5 = bus.funct7b5;
    assign bus0.zero     = bus.zero;

    cw_t cw_main, cw_h0;
    assign cw_main = {bus.pc_we, bus.adr_src, bus.mem_we, bus.ir_we, bus.reg_we, bus.result_src,
                      bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl, bus.instr_done, bus.err};
    assign cw_h0   = {bus0.pc_we, bus0.adr_src, bus0.mem_we, bus0.ir_we, bus0.reg_we, bus0.result_src,
                      bus0.alu_src_a, bus0.alu_src_b, bus0.imm_src, bus0.alu_ctrl, bus0.instr_done, bus0.err};

    always #5 clk = ~clk;

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            0:       return 7'b0000011;
            1:       return 7'b0100011;
            2:       return 7'b0110011;
            3:       return 7'b0010011;
            4:       return 7'b1100011;
            5:       return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit is_legal(input int cls, input logic [2:0] f3);
        case (cls)
            2, 3:    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
            4:       return (f3 == 3'b000);
            6:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int latency(input int cls);
        case (cls)
            0:       return 5;
            4:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic f7, input bit isr);
        case (f3)
            3'b000:  return (isr && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // FETCH outputs with every write enable forced low (reset / hold cycles).
    function automatic cw_t reset_word();
        cw_t w = '0;
        w.alu_src_b  = 2'b10;
        w.result_src = 2'b10;
        return w;
    endfunction

    function automatic cw_t model(input int cls, input int step, input logic [2:0] f3,
                                  input logic f7, input logic z);
        cw_t w = '0;
        if (step == 0) begin
            w = reset_word();
            w.pc_we = 1'b1;
            w.ir_we = 1'b1;
            return w;
        end
        if (step == 1) begin
            w.alu_src_a = 2'b01;
            w.alu_src_b = 2'b01;
            w.imm_src   = 2'b10;
            return w;
        end
        if (!is_legal(cls, f3)) begin
            w.err = 1'b1;
            return w;
        end
        case (cls)
            0, 1: begin
                if (step == 2) begin
                    w.alu_src_a = 2'b10;
                    w.alu_src_b = 2'b01;
                    w.imm_src   = (cls == 1) ? 2'b01 : 2'b00;
                end else if (step == 3) begin
                    w.adr_src    = 1'b1;
                    w.mem_we     = (cls == 1);
                    w.instr_done = (cls == 1);
                end else begin
                    w.result_src = 2'b01;
                    w.reg_we     = 1'b1;
                    w.instr_done = 1'b1;
                end
            end
            2, 3: begin
                if (step == 2) begin
                    w.alu_src_a = 2'b10;
                    w.alu_src_b = (cls == 3) ? 2'b01 : 2'b00;
                    w.alu_ctrl  = alu_ref(f3, f7, cls == 2);
                end else begin
                    w.reg_we     = 1'b1;
                    w.instr_done = 1'b1;
                end
            end
            4: begin
                w.alu_src_a  = 2'b10;
                w.alu_ctrl   = 3'b001;
                w.pc_we      = z;
                w.instr_done = 1'b1;
            end
            default: begin
                if (step == 2) begin
                    w.alu_src_a = 2'b01;
                    w.alu_src_b = 2'b10;
                    w.pc_we     = 1'b1;
                end else begin
                    w.reg_we     = 1'b1;
                    w.instr_done = 1'b1;
                end
            end
        endcase
        return w;
    endfunction

    task automatic check(input string tag, input cw_t o, input cw_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Entered and left at posedge+2 with the DUT ready to present FETCH.
    task automatic do_reset();
        rst = 1'b1;
        #1 check("rst_asserted", cw_main, reset_word());
        #1 rst = 1'b0;
        #1 check("rst_hold", cw_main, reset_word());
        @(posedge clk);
        #2;
    endtask

    task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at);
        int   n;
        logic z;
        bus.op       = op_of(cls);
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        n = is_legal(cls, f3) ? latency(cls) : 22;
        for (int s = 0; s < n; s++) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            bus.zero = z;
            #1 check($sformatf("cls%0d_f3_%0d_step%0d", cls, f3, s), cw_main, model(cls, s, f3, f7, z));
            if (s == abort_at) begin
                do_reset();
                return;
            end
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int          cls;
        logic [2:0]  f3;
        cw_t         h0;
        bus.op       = 7'b0000011;
        bus.funct3   = 3'b010;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #3 check("reset_state", cw_main, reset_word());
        rst = 1'b0;
        h0 = reset_word();
        h0.pc_we = 1'b1;
        h0.ir_we = 1'b1;
        #1 check("hold1_first_fetch", cw_main, reset_word());
        check("hold0_first_fetch", cw_h0, h0);
        @(posedge clk);
        #2 check("hold0_decode", cw_h0, model(0, 1, 3'b010, 1'b0, 1'b0));

        run_instr(0, 3'b010, 1'b0, 2, -1);
        run_instr(1, 3'b010, 1'b0, 2, -1);
        run_instr(2, 3'b000, 1'b1, 2, -1);
        run_instr(2, 3'b000, 1'b0, 2, -1);
        run_instr(3, 3'b000, 1'b1, 2, -1);
        run_instr(4, 3'b000, 1'b0, 1, -1);
        run_instr(4, 3'b000, 1'b0, 0, -1);
        run_instr(5, 3'b000, 1'b0, 2, -1);

        for (int k = 0; k < 60; k++) begin
            cls = $urandom_range(0, 5);
            if (cls == 2 || cls == 3) f3 = legal_f3[$urandom_range(0, 3)];
            else if (cls == 4)        f3 = 3'b000;
            else                      f3 = 3'($urandom_range(0, 7));
            run_instr(cls, f3, 1'($urandom_range(0, 1)), 2, -1);
        end

        run_instr(1, 3'b010, 1'b0, 2, 3);
        run_instr(0, 3'b010, 1'b1, 2, -1);

        run_instr(6, 3'b000, 1'b0, 2, -1);
        do_reset();
        run_instr(2, 3'b001, 1'b0, 2, -1);
        do_reset();
        run_instr(4, 3'b001, 1'b0, 2, -1);
        do_reset();
        run_instr(3, 3'b110, 1'b0, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
